// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
//   Self-check monitor for a RISC-V core. A loadable table holds
//   (instruction count, expected OUTPUT_PORT) entries in ascending
//   instruction order. During a run the entries are checked in sequence
//   against NUM_INST / OUTPUT_PORT. The run ends on HALT, on a failure
//   (optional) or when the watchdog expires.
// Ports:
//   CLK, RSTn          clock (rising edge), synchronous active-low reset
//   LD_WE/IDX/NUM_INST/ANS  table write port (IDLE only)
//   NUM_TEST_CFG       active entry count, latched on START
//   START              begin run from IDLE or DONE
//   NUM_INST, OUTPUT_PORT, HALT   observed core signals
//   BUSY, DONE         run / finished status
//   PASS, TIMEOUT      result flags (valid in DONE)
//   PASS_CNT, FAIL_CNT, CYCLE_CNT  saturating counters
//   FAIL_IDX, FAIL_GOT first failing entry and observed value
module riscv_test_monitor #(
  parameter  int unsigned NUM_TEST     = 32,
  parameter  int unsigned DWIDTH       = 32,
  parameter  int unsigned CWIDTH       = 32,
  parameter  int unsigned MAX_CYCLES   = 1000,
  parameter  int unsigned STOP_ON_FAIL = 1,
  localparam int unsigned IW           = $clog2(NUM_TEST)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              LD_WE,
  input  logic [IW-1:0]     LD_IDX,
  input  logic [31:0]       LD_NUM_INST,
  input  logic [DWIDTH-1:0] LD_ANS,
  input  logic [IW:0]       NUM_TEST_CFG,
  input  logic              START,
  input  logic [31:0]       NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic              TIMEOUT,
  output logic [CWIDTH-1:0] PASS_CNT,
  output logic [CWIDTH-1:0] FAIL_CNT,
  output logic [IW:0]       FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_GOT,
  output logic [CWIDTH-1:0] CYCLE_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]       r_exp_inst [NUM_TEST];
  logic [DWIDTH-1:0] r_exp_ans  [NUM_TEST];

  logic [IW:0]       r_cfg, r_ptr, r_fail_idx;
  logic              r_pass, r_timeout;
  logic [CWIDTH-1:0] r_pass_cnt, r_fail_cnt, r_cyc;
  logic [DWIDTH-1:0] r_fail_got;

  logic              w_ptr_ok, w_hit, w_miss, w_match, w_fail;
  logic              w_stop_to, w_stop;
  logic [IW-1:0]     w_idx;
  logic [IW:0]       w_ptr_nxt, w_cfg_in;
  logic [CWIDTH-1:0] w_cyc_inc, w_pass_nxt, w_fail_nxt;

  // Table storage is deliberately not reset so it survives RSTn.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && LD_WE) begin
      r_exp_inst[LD_IDX] <= LD_NUM_INST;
      r_exp_ans[LD_IDX]  <= LD_ANS;
    end
  end

  assign w_cfg_in = (NUM_TEST_CFG > (IW+1)'(NUM_TEST)) ? (IW+1)'(NUM_TEST) : NUM_TEST_CFG;

  // Index is only meaningful while ptr < cfg; force 0 otherwise so the
  // array is never addressed out of range.
  assign w_ptr_ok = (r_ptr < r_cfg);
  assign w_idx    = w_ptr_ok ? r_ptr[IW-1:0] : '0;
  assign w_hit    = w_ptr_ok && (NUM_INST == r_exp_inst[w_idx]);
  assign w_miss   = w_ptr_ok && (NUM_INST >  r_exp_inst[w_idx]);
  assign w_match  = w_hit && (OUTPUT_PORT == r_exp_ans[w_idx]);
  assign w_fail   = (w_hit && !w_match) || w_miss;

  assign w_ptr_nxt  = (w_hit || w_miss) ? r_ptr + 1'b1 : r_ptr;
  assign w_cyc_inc  = r_cyc + 1'b1;
  assign w_pass_nxt = (w_match && r_pass_cnt != '1) ? r_pass_cnt + 1'b1 : r_pass_cnt;
  assign w_fail_nxt = (w_fail  && r_fail_cnt != '1) ? r_fail_cnt + 1'b1 : r_fail_cnt;

  assign w_stop_to = (w_cyc_inc == CWIDTH'(MAX_CYCLES));
  assign w_stop    = (w_fail && (STOP_ON_FAIL != 0)) || HALT || w_stop_to;

  always_ff @(posedge CLK) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START)  w_state_nxt = S_RUN;
      S_RUN:   if (w_stop) w_state_nxt = S_DONE;
      S_DONE:  if (START)  w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_cfg      <= '0;
      r_ptr      <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_cyc      <= '0;
      r_fail_idx <= '0;
      r_fail_got <= '0;
    end else if (r_state == S_RUN) begin
      r_cyc      <= (r_cyc != '1) ? w_cyc_inc : r_cyc;
      r_pass_cnt <= w_pass_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_ptr      <= w_ptr_nxt;
      if (w_fail && r_fail_cnt == '0) begin
        r_fail_idx <= r_ptr;
        r_fail_got <= w_hit ? OUTPUT_PORT : '0;
      end
      if (w_stop) begin
        r_timeout <= w_stop_to;
        r_pass    <= (w_fail_nxt == '0) && (w_ptr_nxt == r_cfg) && !w_stop_to;
        // Halting with entries still pending reports where checking stopped,
        // unless a real failure was already recorded.
        if (HALT && w_ptr_nxt != r_cfg && w_fail_nxt == '0)
          r_fail_idx <= w_ptr_nxt;
      end
    end else if (START) begin
      r_cfg      <= w_cfg_in;
      r_ptr      <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_cyc      <= '0;
      r_fail_idx <= '0;
      r_fail_got <= '0;
    end
  end

  assign BUSY      = (r_state == S_RUN);
  assign DONE      = (r_state == S_DONE);
  assign PASS      = r_pass;
  assign TIMEOUT   = r_timeout;
  assign PASS_CNT  = r_pass_cnt;
  assign FAIL_CNT  = r_fail_cnt;
  assign FAIL_IDX  = r_fail_idx;
  assign FAIL_GOT  = r_fail_got;
  assign CYCLE_CNT = r_cyc;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor
//   Directed bench for riscv_test_monitor. Two instances share all inputs:
//   dut_a stops on first failure, dut_b keeps running; both time out at 16.
module tb_riscv_test_monitor;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        LD_WE = 1'b0;
  logic [1:0]  LD_IDX = '0;
  logic [31:0] LD_NUM_INST = '0;
  logic [31:0] LD_ANS = '0;
  logic [2:0]  CFG = '0;
  logic        START = 1'b0;
  logic [31:0] NUM_INST = '0;
  logic [31:0] OUTP = '0;
  logic        HALT = 1'b0;

  logic        a_busy, a_done, a_pass, a_tmo;
  logic [31:0] a_pcnt, a_fcnt, a_fgot, a_cyc;
  logic [2:0]  a_fidx;
  logic        b_busy, b_done, b_pass, b_tmo;
  logic [31:0] b_pcnt, b_fcnt, b_fgot, b_cyc;
  logic [2:0]  b_fidx;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  riscv_test_monitor #(.NUM_TEST(4), .DWIDTH(32), .CWIDTH(32),
                       .MAX_CYCLES(16), .STOP_ON_FAIL(1)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .LD_WE(LD_WE), .LD_IDX(LD_IDX),
    .LD_NUM_INST(LD_NUM_INST), .LD_ANS(LD_ANS), .NUM_TEST_CFG(CFG),
    .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTP), .HALT(HALT),
    .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .TIMEOUT(a_tmo),
    .PASS_CNT(a_pcnt), .FAIL_CNT(a_fcnt), .FAIL_IDX(a_fidx),
    .FAIL_GOT(a_fgot), .CYCLE_CNT(a_cyc));

  riscv_test_monitor #(.NUM_TEST(4), .DWIDTH(32), .CWIDTH(32),
                       .MAX_CYCLES(16), .STOP_ON_FAIL(0)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .LD_WE(LD_WE), .LD_IDX(LD_IDX),
    .LD_NUM_INST(LD_NUM_INST), .LD_ANS(LD_ANS), .NUM_TEST_CFG(CFG),
    .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTP), .HALT(HALT),
    .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .TIMEOUT(b_tmo),
    .PASS_CNT(b_pcnt), .FAIL_CNT(b_fcnt), .FAIL_IDX(b_fidx),
    .FAIL_GOT(b_fgot), .CYCLE_CNT(b_cyc));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [1:0] idx, input logic [31:0] ni, input logic [31:0] ans);
    LD_WE = 1'b1; LD_IDX = idx; LD_NUM_INST = ni; LD_ANS = ans;
    tick();
    LD_WE = 1'b0;
  endtask

  task automatic start(input logic [2:0] cfg);
    CFG = cfg; START = 1'b1; HALT = 1'b0;
    tick();
    START = 1'b0;
  endtask

  task automatic drive(input logic [31:0] ni, input logic [31:0] o, input logic h);
    NUM_INST = ni; OUTP = o; HALT = h;
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_pass", {31'd0, a_pass}, 32'd0);
    chk("rst_pcnt", a_pcnt, 32'd0);
    chk("rst_cyc",  a_cyc,  32'd0);
    RSTn = 1'b1;

    load(2'd0, 32'd1, 32'h0);
    load(2'd1, 32'd2, 32'h5);
    load(2'd2, 32'd3, 32'h7);
    load(2'd3, 32'd4, 32'h9);

    // all entries match, then HALT
    start(3'd3);
    chk("t1_busy", {31'd0, a_busy}, 32'd1);
    drive(0, 32'h0, 0); drive(1, 32'h0, 0); drive(2, 32'h5, 0); drive(3, 32'h7, 0);
    chk("t1_pcnt_run", a_pcnt, 32'd3);
    drive(3, 32'h7, 1);
    chk("t1_done", {31'd0, a_done}, 32'd1);
    chk("t1_pass", {31'd0, a_pass}, 32'd1);
    chk("t1_pcnt", a_pcnt, 32'd3);
    chk("t1_fcnt", a_fcnt, 32'd0);
    chk("t1_cyc",  a_cyc,  32'd5);
    chk("t1_tmo",  {31'd0, a_tmo}, 32'd0);

    // table write outside IDLE must be ignored
    load(2'd1, 32'd2, 32'h9);

    // mismatch at the last entry
    start(3'd3);
    chk("t2_clr_pass", {31'd0, a_pass}, 32'd0);
    chk("t2_clr_cyc",  a_cyc, 32'd0);
    drive(1, 32'h0, 0); drive(2, 32'h5, 0); drive(3, 32'h6, 0);
    chk("t2_done", {31'd0, a_done}, 32'd1);
    chk("t2_pass", {31'd0, a_pass}, 32'd0);
    chk("t2_fidx", {29'd0, a_fidx}, 32'd2);
    chk("t2_fgot", a_fgot, 32'h6);
    chk("t2_fcnt", a_fcnt, 32'd1);
    chk("t2_pcnt", a_pcnt, 32'd2);
    chk("t2_b_busy", {31'd0, b_busy}, 32'd1);
    drive(3, 32'h6, 1);
    chk("t2_b_done", {31'd0, b_done}, 32'd1);
    chk("t2_b_pass", {31'd0, b_pass}, 32'd0);
    chk("t2_b_fcnt", b_fcnt, 32'd1);
    chk("t2_a_hold_cyc", a_cyc, 32'd3);

    // skipped entry counted as a miss
    start(3'd3);
    drive(1, 32'h0, 0); drive(3, 32'h7, 0);
    chk("t3_b_fcnt", b_fcnt, 32'd1);
    chk("t3_b_fidx", {29'd0, b_fidx}, 32'd1);
    chk("t3_b_fgot", b_fgot, 32'h0);
    chk("t3_b_busy", {31'd0, b_busy}, 32'd1);
    chk("t3_a_done", {31'd0, a_done}, 32'd1);
    drive(3, 32'h7, 0);
    chk("t3_b_pcnt_run", b_pcnt, 32'd2);
    drive(3, 32'h7, 1);
    chk("t3_b_done", {31'd0, b_done}, 32'd1);
    chk("t3_b_pass", {31'd0, b_pass}, 32'd0);
    chk("t3_b_fcnt_end", b_fcnt, 32'd1);
    chk("t3_b_pcnt", b_pcnt, 32'd2);

    // HALT with an entry still unchecked
    start(3'd3);
    drive(1, 32'h0, 0); drive(2, 32'h5, 1);
    chk("t4_done", {31'd0, a_done}, 32'd1);
    chk("t4_pass", {31'd0, a_pass}, 32'd0);
    chk("t4_fidx", {29'd0, a_fidx}, 32'd2);
    chk("t4_pcnt", a_pcnt, 32'd2);
    chk("t4_fcnt", a_fcnt, 32'd0);

    // empty table: HALT alone passes
    start(3'd0);
    drive(0, 32'h0, 1);
    chk("cfg0_done", {31'd0, a_done}, 32'd1);
    chk("cfg0_pass", {31'd0, a_pass}, 32'd1);

    // oversize cfg clamps to the table depth
    start(3'd7);
    drive(1, 32'h0, 0); drive(2, 32'h5, 0); drive(3, 32'h7, 0); drive(4, 32'h9, 1);
    chk("clamp_pass", {31'd0, a_pass}, 32'd1);
    chk("clamp_pcnt", a_pcnt, 32'd4);

    // watchdog
    start(3'd3);
    for (int i = 0; i < 15; i++) drive(0, 32'h0, 0);
    chk("to_busy", {31'd0, a_busy}, 32'd1);
    chk("to_cyc15", a_cyc, 32'd15);
    drive(0, 32'h0, 0);
    chk("to_done", {31'd0, a_done}, 32'd1);
    chk("to_tmo",  {31'd0, a_tmo}, 32'd1);
    chk("to_cyc",  a_cyc, 32'd16);
    chk("to_pass", {31'd0, a_pass}, 32'd0);

    // restart clears, then reset mid-run
    start(3'd3);
    chk("rs_tmo", {31'd0, a_tmo}, 32'd0);
    chk("rs_cyc", a_cyc, 32'd0);
    chk("rs_busy", {31'd0, a_busy}, 32'd1);
    drive(1, 32'h0, 0);
    chk("rs_pcnt", a_pcnt, 32'd1);
    RSTn = 1'b0;
    tick();
    chk("mr_busy", {31'd0, a_busy}, 32'd0);
    chk("mr_done", {31'd0, a_done}, 32'd0);
    chk("mr_pcnt", a_pcnt, 32'd0);
    chk("mr_cyc",  a_cyc, 32'd0);
    RSTn = 1'b1;

    // table survived reset
    start(3'd3);
    drive(1, 32'h0, 0); drive(2, 32'h5, 0); drive(3, 32'h7, 0); drive(3, 32'h7, 1);
    chk("rr_done", {31'd0, a_done}, 32'd1);
    chk("rr_pass", {31'd0, a_pass}, 32'd1);
    chk("rr_pcnt", a_pcnt, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
